// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control FSM: state encodings,
// opcodes and the datapath select codes driven by the controller.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_RD    = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WR    = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: sequences each instruction,
// drives datapath selects and write enables, and counts retired instructions.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             ALU_src_a,
    output logic [1:0]       ALU_src_b,
    output logic [1:0]       ALU_op,
    output logic [1:0]       pc_source,
    output logic             illegal_op,
    output logic [3:0]       state_dbg,
    output logic [CNT_W-1:0] instr_count
);

    state_t state, next_state;
    logic   retire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            instr_count <= '0;
        end else begin
            state <= next_state;
            if (retire) instr_count <= instr_count + CNT_W'(1);
        end
    end

    always_comb begin
        next_state    = state;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        ALU_src_a     = 1'b0;
        ALU_src_b     = SRCB_REG;
        ALU_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;
        illegal_op    = 1'b0;

        case (state)
            FETCH: begin
                mem_read  = 1'b1;
                ALU_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) next_state = DECODE;
            end
            DECODE: begin
                ALU_src_b = SRCB_IMM_SH2;
                case (opcode)
                    OP_RTYPE:     next_state = R_EXEC;
                    OP_LW, OP_SW: next_state = MEM_ADDR;
                    OP_BEQ:       next_state = BRANCH;
                    OP_J:         next_state = JUMP;
                    OP_ADDI:      next_state = ADDI_EXEC;
                    default: begin
                        illegal_op = 1'b1;
                        next_state = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                ALU_src_a  = 1'b1;
                ALU_src_b  = SRCB_IMM;
                next_state = (opcode == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) next_state = MEM_WB;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    retire     = 1'b1;
                    next_state = FETCH;
                end
            end
            R_EXEC: begin
                ALU_src_a  = 1'b1;
                ALU_op     = ALUOP_FUNCT;
                next_state = R_WB;
            end
            R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                ALU_src_a     = 1'b1;
                ALU_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                retire        = 1'b1;
                next_state    = FETCH;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                retire     = 1'b1;
                next_state = FETCH;
            end
            ADDI_EXEC: begin
                ALU_src_a  = 1'b1;
                ALU_src_b  = SRCB_IMM;
                next_state = ADDI_WB;
            end
            ADDI_WB: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            default: next_state = FETCH;
        endcase

        // Reset must suppress every side effect in the same cycle it is seen.
        if (reset) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            mem_write     = 1'b0;
            mem_read      = 1'b0;
            illegal_op    = 1'b0;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction state paths and
// per-state output expectations are built from the instruction-level rules.
module tb_multicycle_control;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEM_ADDR = 2, S_MEM_RD = 3,
                   S_MEM_WB = 4, S_MEM_WR = 5, S_R_EXEC = 6, S_R_WB = 7,
                   S_BRANCH = 8, S_JUMP = 9, S_ADDI_EXEC = 10, S_ADDI_WB = 11;

    localparam logic [5:0] T_RTYPE = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011,
                           T_BEQ = 6'b000100, T_J = 6'b000010, T_ADDI = 6'b001000;

    logic        clk = 1'b0;
    logic        reset, mem_ready;
    logic [5:0]  opcode;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, ALU_src_a, illegal_op;
    logic [1:0]  ALU_src_b, ALU_op, pc_source;
    logic [3:0]  state_dbg;
    logic [31:0] instr_count;

    logic        d3_pc_write, d3_pc_write_cond, d3_i_or_d, d3_mem_read, d3_mem_write;
    logic        d3_ir_write, d3_mem_to_reg, d3_reg_dst, d3_reg_write, d3_ALU_src_a;
    logic        d3_illegal_op;
    logic [1:0]  d3_ALU_src_b, d3_ALU_op, d3_pc_source;
    logic [3:0]  d3_state_dbg;
    logic [2:0]  d3_instr_count;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] cnt_model;
    logic [5:0]  cur_op;

    always #5 clk = ~clk;

    multicycle_control #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .ALU_src_a(ALU_src_a), .ALU_src_b(ALU_src_b), .ALU_op(ALU_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .state_dbg(state_dbg),
        .instr_count(instr_count)
    );

    // Narrow-counter instance exercises wrap-around in a reachable cycle count.
    multicycle_control #(.CNT_W(3)) dut3 (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(d3_pc_write), .pc_write_cond(d3_pc_write_cond), .i_or_d(d3_i_or_d),
        .mem_read(d3_mem_read), .mem_write(d3_mem_write), .ir_write(d3_ir_write),
        .mem_to_reg(d3_mem_to_reg), .reg_dst(d3_reg_dst), .reg_write(d3_reg_write),
        .ALU_src_a(d3_ALU_src_a), .ALU_src_b(d3_ALU_src_b), .ALU_op(d3_ALU_op),
        .pc_source(d3_pc_source), .illegal_op(d3_illegal_op), .state_dbg(d3_state_dbg),
        .instr_count(d3_instr_count)
    );

    logic [16:0] dut_outs;
    assign dut_outs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                       mem_to_reg, reg_dst, reg_write, ALU_src_a, ALU_src_b, ALU_op,
                       pc_source, illegal_op};

    function automatic bit is_legal(input logic [5:0] op);
        return op == T_RTYPE || op == T_LW || op == T_SW || op == T_BEQ ||
               op == T_J || op == T_ADDI;
    endfunction

    function automatic logic [16:0] exp_outs(input int st, input logic mr,
                                             input logic [5:0] op, input logic rst);
        logic pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, sa, ill;
        logic [1:0] sb, aop, ps;
        {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, sa, ill} = '0;
        sb = 2'b00; aop = 2'b00; ps = 2'b00;
        case (st)
            S_FETCH:     begin mrd = 1'b1; sb = 2'b01; irw = mr; pw = mr; end
            S_DECODE:    begin sb = 2'b11; ill = !is_legal(op); end
            S_MEM_ADDR:  begin sa = 1'b1; sb = 2'b10; end
            S_MEM_RD:    begin mrd = 1'b1; iod = 1'b1; end
            S_MEM_WB:    begin rw = 1'b1; m2r = 1'b1; end
            S_MEM_WR:    begin mwr = 1'b1; iod = 1'b1; end
            S_R_EXEC:    begin sa = 1'b1; aop = 2'b10; end
            S_R_WB:      begin rw = 1'b1; rd = 1'b1; end
            S_BRANCH:    begin sa = 1'b1; aop = 2'b01; pwc = 1'b1; ps = 2'b01; end
            S_JUMP:      begin pw = 1'b1; ps = 2'b10; end
            S_ADDI_EXEC: begin sa = 1'b1; sb = 2'b10; end
            S_ADDI_WB:   begin rw = 1'b1; end
            default: ;
        endcase
        if (rst) {pw, pwc, irw, rw, mwr, mrd, ill} = '0;
        return {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, sa, sb, aop, ps, ill};
    endfunction

    // One clock cycle: drive at the falling edge, sample 1 ns later.
    task automatic step(input int st, input logic mr, input logic rst);
        logic [16:0] exp;
        @(negedge clk);
        mem_ready = mr;
        reset     = rst;
        opcode    = cur_op;
        #1;
        exp = exp_outs(st, mr, cur_op, rst);
        checks++;
        if (state_dbg !== 4'(st)) begin
            errors++;
            $display("FAIL state: got %0d want %0d (op %b)", state_dbg, st, cur_op);
        end
        checks++;
        if (dut_outs !== exp) begin
            errors++;
            $display("FAIL outputs st=%0d mr=%b rst=%b: got %h want %h", st, mr, rst, dut_outs, exp);
        end
        checks++;
        if (instr_count !== cnt_model) begin
            errors++;
            $display("FAIL instr_count: got %0d want %0d", instr_count, cnt_model);
        end
        checks++;
        if (d3_instr_count !== cnt_model[2:0] || d3_state_dbg !== 4'(st)) begin
            errors++;
            $display("FAIL narrow_dut: count %0d state %0d want count %0d state %0d",
                     d3_instr_count, d3_state_dbg, cnt_model[2:0], st);
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input int unsigned wmax);
        int path[$];
        int unsigned w;
        cur_op = op;
        path = {S_FETCH, S_DECODE};
        case (op)
            T_RTYPE: begin path.push_back(S_R_EXEC); path.push_back(S_R_WB); end
            T_LW:    begin path.push_back(S_MEM_ADDR); path.push_back(S_MEM_RD);
                           path.push_back(S_MEM_WB); end
            T_SW:    begin path.push_back(S_MEM_ADDR); path.push_back(S_MEM_WR); end
            T_BEQ:   path.push_back(S_BRANCH);
            T_J:     path.push_back(S_JUMP);
            T_ADDI:  begin path.push_back(S_ADDI_EXEC); path.push_back(S_ADDI_WB); end
            default: ;
        endcase
        foreach (path[i]) begin
            if (path[i] == S_FETCH || path[i] == S_MEM_RD || path[i] == S_MEM_WR) begin
                w = $urandom_range(wmax, 0);
                repeat (w) step(path[i], 1'b0, 1'b0);
                step(path[i], 1'b1, 1'b0);
            end else begin
                step(path[i], 1'($urandom_range(1, 0)), 1'b0);
            end
        end
        if (is_legal(op)) cnt_model = cnt_model + 32'd1;
    endtask

    task automatic test_reset;
        cur_op = T_LW;
        step(S_FETCH, 1'b1, 1'b0);
        step(S_DECODE, 1'b1, 1'b0);
        step(S_MEM_ADDR, 1'b1, 1'b0);
        step(S_MEM_RD, 1'b0, 1'b0);
        step(S_MEM_RD, 1'b0, 1'b1);
        cnt_model = '0;
        step(S_FETCH, 1'b1, 1'b1);
    endtask

    task automatic test_lw;
        run_instr(T_LW, 0);
    endtask

    task automatic test_sw_wait;
        cur_op = T_SW;
        step(S_FETCH, 1'b1, 1'b0);
        step(S_DECODE, 1'b1, 1'b0);
        step(S_MEM_ADDR, 1'b1, 1'b0);
        repeat (3) step(S_MEM_WR, 1'b0, 1'b0);
        step(S_MEM_WR, 1'b1, 1'b0);
        cnt_model = cnt_model + 32'd1;
    endtask

    task automatic test_r_beq_j;
        run_instr(T_RTYPE, 0);
        run_instr(T_BEQ, 0);
        run_instr(T_J, 0);
    endtask

    task automatic test_illegal;
        run_instr(6'b111111, 0);
        run_instr(6'b000001, 1);
    endtask

    task automatic test_addi_wrap;
        while (cnt_model[2:0] != 3'd7) run_instr(T_ADDI, 1);
        run_instr(T_ADDI, 1);
        @(posedge clk);
        #1;
        checks++;
        if (d3_instr_count !== 3'd0) begin
            errors++;
            $display("FAIL wrap: got %0d want 0", d3_instr_count);
        end
    endtask

    task automatic test_random;
        logic [5:0] ops[6];
        ops = '{T_RTYPE, T_LW, T_SW, T_BEQ, T_J, T_ADDI};
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(7, 0) == 0) run_instr(6'($urandom), 3);
            else run_instr(ops[$urandom_range(5, 0)], 3);
        end
    endtask

    task automatic test_reset_mid_wr;
        cur_op = T_SW;
        step(S_FETCH, 1'b1, 1'b0);
        step(S_DECODE, 1'b1, 1'b0);
        step(S_MEM_ADDR, 1'b1, 1'b0);
        step(S_MEM_WR, 1'b0, 1'b0);
        step(S_MEM_WR, 1'b1, 1'b1);
        cnt_model = '0;
        step(S_FETCH, 1'b1, 1'b1);
        run_instr(T_BEQ, 0);
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b0;
        opcode    = '0;
        cur_op    = '0;
        cnt_model = '0;
        repeat (2) @(posedge clk);
        test_reset;
        test_lw;
        test_sw_wait;
        test_r_beq_j;
        test_illegal;
        test_addi_wrap;
        test_random;
        test_reset_mid_wr;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
